// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the two-port block RAM arbiter.
package bram_port_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Requester indices (bit positions in the packed request vector)
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/bram_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_pick2
    import bram_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt_valid_c,
    output logic       o_gnt_idx_c
);

    // Pick the single requester, or the one that was not granted last on a tie
    always_comb begin
        o_gnt_valid_c = |i_req;
        o_gnt_idx_c   = PORT_A;
        case (i_req)
            2'b01:   o_gnt_idx_c = PORT_A;
            2'b10:   o_gnt_idx_c = PORT_B;
            2'b11:   o_gnt_idx_c = ~i_last;
            default: o_gnt_idx_c = PORT_A;
        endcase
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port block RAM between an instruction-fetch port (A) and a load/store port (B).
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(RD_LAT) + 1;

    state_t            r_state;
    logic              r_winner;
    logic              r_last;
    logic              r_wr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_din;

    rr_pick2 u_pick (
        .i_req         ({b_req, a_req}),
        .i_last        (r_last),
        .o_gnt_valid_c (w_gnt_valid),
        .o_gnt_idx_c   (w_gnt_idx)
    );

    assign w_sel_we   = (w_gnt_idx == PORT_B) ? b_we   : a_we;
    assign w_sel_addr = (w_gnt_idx == PORT_B) ? b_addr : a_addr;
    assign w_sel_din  = (w_gnt_idx == PORT_B) ? b_din  : a_din;

    // Grant, drive the RAM, wait out its read latency, then return data and pulse done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_winner <= PORT_A;
            r_last   <= PORT_B;
            r_wr     <= 1'b0;
            r_cnt    <= '0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The done cycle is a turnaround: the served port still shows its old req
                    if (w_gnt_valid && !a_done && !b_done) begin
                        r_winner <= w_gnt_idx;
                        r_wr     <= w_sel_we;
                        mem_addr <= w_sel_addr;
                        mem_din  <= w_sel_din;
                        mem_we   <= w_sel_we;
                        busy     <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we  <= 1'b0;
                    r_cnt   <= CNT_W'(RD_LAT - 1);
                    r_state <= (RD_LAT == 1) ? DONE : WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (r_winner == PORT_A) begin
                        a_done <= 1'b1;
                        if (!r_wr) a_rdata <= mem_dout;
                    end else begin
                        b_done <= 1'b1;
                        if (!r_wr) b_rdata <= mem_dout;
                    end
                    r_last  <= r_winner;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
